// File: rtl/id_bypass_stage.sv
// id_bypass_stage: decode pipeline register with prioritised operand bypass,
// ready-aware interlock and a saturating stall-cycle counter.
module id_bypass_stage #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32,
  parameter int INST_W = 32,
  parameter int AW     = 5,
  parameter int NSRC   = 2,
  parameter int NFWD   = 3,
  parameter int CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   fs2ds_valid,
  input  logic [PC_W-1:0]        fs2ds_pc,
  input  logic [INST_W-1:0]      fs2ds_inst,
  output logic                   ds_allowin,
  input  logic                   es_allowin,
  output logic                   ds2es_valid,
  output logic [PC_W-1:0]        ds_pc,
  output logic [INST_W-1:0]      ds_inst,
  input  logic                   flush,
  input  logic [NSRC-1:0]        src_en,
  input  logic [NSRC*AW-1:0]     src_addr,
  input  logic [NSRC*DATA_W-1:0] rf_rdata,
  input  logic [NFWD-1:0]        fwd_valid,
  input  logic [NFWD-1:0]        fwd_we,
  input  logic [NFWD*AW-1:0]     fwd_dest,
  input  logic [NFWD-1:0]        fwd_ready,
  input  logic [NFWD*DATA_W-1:0] fwd_data,
  output logic [NSRC*DATA_W-1:0] src_val,
  output logic                   stall,
  output logic [CNT_W-1:0]       stall_cnt,
  input  logic                   clr_cnt
);
  logic              ds_valid_q, ds_valid_d;
  logic [PC_W-1:0]   ds_pc_q, ds_pc_d;
  logic [INST_W-1:0] ds_inst_q, ds_inst_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [NSRC-1:0]   hazard;
  logic              ds_ready_go, load;
  // Channels are scanned oldest-first so the youngest match overwrites both value and hazard.
  always_comb begin
    src_val = '0;
    hazard  = '0;
    for (int k = 0; k < NSRC; k++) begin
      src_val[k*DATA_W +: DATA_W] = rf_rdata[k*DATA_W +: DATA_W];
      for (int i = NFWD-1; i >= 0; i--)
        if (fwd_valid[i] && fwd_we[i] && src_en[k] && src_addr[k*AW +: AW] != '0 &&
            fwd_dest[i*AW +: AW] == src_addr[k*AW +: AW]) begin
          src_val[k*DATA_W +: DATA_W] = fwd_data[i*DATA_W +: DATA_W];
          hazard[k] = ~fwd_ready[i];
        end
    end
  end
  assign stall       = ds_valid_q & |hazard;
  assign ds_ready_go = ~stall;
  assign ds2es_valid = ds_valid_q & ds_ready_go & ~flush;
  assign ds_allowin  = ~ds_valid_q | (ds_ready_go & es_allowin);
  assign load        = fs2ds_valid & ds_allowin & ~flush;
  always_comb begin
    ds_valid_d  = flush ? 1'b0 : ds_allowin ? fs2ds_valid : ds_valid_q;
    ds_pc_d     = load ? fs2ds_pc : ds_pc_q;
    ds_inst_d   = load ? fs2ds_inst : ds_inst_q;
    stall_cnt_d = clr_cnt ? '0 :
                  (stall & ~flush & ~&stall_cnt_q) ? stall_cnt_q + 1'b1 : stall_cnt_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      ds_valid_q  <= 1'b0;
      ds_pc_q     <= '0;
      ds_inst_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      ds_valid_q  <= ds_valid_d;
      ds_pc_q     <= ds_pc_d;
      ds_inst_q   <= ds_inst_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end
  assign ds_pc     = ds_pc_q;
  assign ds_inst   = ds_inst_q;
  assign stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_id_bypass_stage.sv
// tb_id_bypass_stage: directed stimulus with a per-cycle reference model and literal spot checks.
module tb_id_bypass_stage;
  localparam int DW = 32, PW = 32, IW = 32, AW = 5, NSRC = 2, NFWD = 3, CW = 4;
  logic clk = 0, reset = 1;
  logic fs2ds_valid = 0, es_allowin = 1, flush = 0, clr_cnt = 0;
  logic [PW-1:0] fs2ds_pc = '0;
  logic [IW-1:0] fs2ds_inst = '0;
  logic [NSRC-1:0] src_en = '0;
  logic [NSRC*AW-1:0] src_addr = '0;
  logic [NSRC*DW-1:0] rf_rdata = '0;
  logic [NFWD-1:0] fwd_valid = '0, fwd_we = '0, fwd_ready = '0;
  logic [NFWD*AW-1:0] fwd_dest = '0;
  logic [NFWD*DW-1:0] fwd_data = '0;
  logic ds_allowin, ds2es_valid, stall;
  logic [PW-1:0] ds_pc;
  logic [IW-1:0] ds_inst;
  logic [NSRC*DW-1:0] src_val;
  logic [CW-1:0] stall_cnt;
  int compared = 0, mismatched = 0;
  bit armed = 0;

  id_bypass_stage #(.DATA_W(DW), .PC_W(PW), .INST_W(IW), .AW(AW), .NSRC(NSRC), .NFWD(NFWD), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .fs2ds_valid(fs2ds_valid), .fs2ds_pc(fs2ds_pc), .fs2ds_inst(fs2ds_inst),
    .ds_allowin(ds_allowin), .es_allowin(es_allowin), .ds2es_valid(ds2es_valid), .ds_pc(ds_pc),
    .ds_inst(ds_inst), .flush(flush), .src_en(src_en), .src_addr(src_addr), .rf_rdata(rf_rdata),
    .fwd_valid(fwd_valid), .fwd_we(fwd_we), .fwd_dest(fwd_dest), .fwd_ready(fwd_ready),
    .fwd_data(fwd_data), .src_val(src_val), .stall(stall), .stall_cnt(stall_cnt), .clr_cnt(clr_cnt));

  always #5 clk = ~clk;

  // Reference model state and derived outputs
  bit m_valid;
  int unsigned m_pc, m_inst, m_cnt;
  bit e_stall, e_issue, e_allowin;
  logic [DW-1:0] e_val [NSRC];

  function automatic void eval();
    bit any_hz = 0;
    for (int k = 0; k < NSRC; k++) begin
      e_val[k] = rf_rdata[k*DW +: DW];
      for (int i = 0; i < NFWD; i++)
        if (fwd_valid[i] && fwd_we[i] && src_en[k] && src_addr[k*AW +: AW] != 0 &&
            fwd_dest[i*AW +: AW] == src_addr[k*AW +: AW]) begin
          e_val[k] = fwd_data[i*DW +: DW];
          if (!fwd_ready[i]) any_hz = 1;
          break;
        end
    end
    e_stall   = m_valid && any_hz;
    e_issue   = m_valid && !e_stall && !flush;
    e_allowin = !m_valid || (!e_stall && es_allowin);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    eval();
    if (reset) begin
      m_valid = 0; m_pc = 0; m_inst = 0; m_cnt = 0;
    end else begin
      if (fs2ds_valid && e_allowin && !flush) begin m_pc = fs2ds_pc; m_inst = fs2ds_inst; end
      if (flush) m_valid = 0;
      else if (e_allowin) m_valid = fs2ds_valid;
      if (clr_cnt) m_cnt = 0;
      else if (e_stall && !flush && m_cnt < (1 << CW) - 1) m_cnt++;
    end
  end

  always @(negedge clk) if (armed) begin
    eval();
    chk("model_ds2es_valid", ds2es_valid, e_issue);
    chk("model_ds_allowin", ds_allowin, e_allowin);
    chk("model_stall", stall, e_stall);
    chk("model_ds_pc", ds_pc, m_pc);
    chk("model_ds_inst", ds_inst, m_inst);
    chk("model_stall_cnt", stall_cnt, m_cnt);
    for (int k = 0; k < NSRC; k++) chk("model_src_val", src_val[k*DW +: DW], e_val[k]);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int i, input bit v, input bit we, input int dest, input bit rdy, input int data);
    fwd_valid[i] = v; fwd_we[i] = we; fwd_ready[i] = rdy;
    fwd_dest[i*AW +: AW] = dest[AW-1:0];
    fwd_data[i*DW +: DW] = data;
  endtask

  initial begin
    step(2);
    armed = 1;
    #1;
    chk("reset_ds2es_valid", ds2es_valid, 0);
    chk("reset_ds_allowin", ds_allowin, 1);
    chk("reset_stall_cnt", stall_cnt, 0);
    chk("reset_ds_pc", ds_pc, 0);
    reset = 0;
    fs2ds_valid = 1; fs2ds_pc = 32'h1C000000; fs2ds_inst = 32'h02800421;
    step(1);
    fs2ds_valid = 0; #1;
    chk("first_issue", ds2es_valid, 1);
    chk("first_pc", ds_pc, 32'h1C000000);
    chk("first_inst", ds_inst, 32'h02800421);
    chk("first_stall", stall, 0);
    // Bypass priority
    step(1);
    src_en = 2'b01; src_addr[0 +: AW] = 5; rf_rdata[0 +: DW] = 32'h11;
    set_ch(0, 1, 1, 5, 1, 32'hAA); set_ch(1, 1, 1, 5, 1, 32'hBB); #1;
    chk("byp_ch0", src_val[0 +: DW], 32'hAA);
    step(1); fwd_valid[0] = 0; #1;
    chk("byp_ch1", src_val[0 +: DW], 32'hBB);
    step(1); fwd_valid[1] = 0; #1;
    chk("byp_rf", src_val[0 +: DW], 32'h11);
    step(1); src_addr[0 +: AW] = 0; set_ch(0, 1, 1, 0, 1, 32'hAA); #1;
    chk("byp_r0", src_val[0 +: DW], 32'h11);
    // Load-use: younger unready ch0 must not be masked by ready ch2
    step(1);
    set_ch(0, 1, 1, 7, 0, 32'h0); set_ch(1, 0, 0, 0, 0, 0); set_ch(2, 1, 1, 7, 1, 32'h999);
    src_en = 2'b10; src_addr[AW +: AW] = 7; rf_rdata[DW +: DW] = 32'h22;
    fs2ds_valid = 1; fs2ds_pc = 32'h1C000004; fs2ds_inst = 32'h1;
    step(1);
    fs2ds_pc = 32'h1C000008; fs2ds_inst = 32'h2; #1;
    chk("lu_stall", stall, 1);
    chk("lu_allowin", ds_allowin, 0);
    chk("lu_no_issue", ds2es_valid, 0);
    step(3);
    fwd_ready[0] = 1; fwd_data[0 +: DW] = 32'h1234; #1;
    chk("lu_issue", ds2es_valid, 1);
    chk("lu_val", src_val[DW +: DW], 32'h1234);
    chk("lu_cnt", stall_cnt, 3);
    chk("lu_pc_held", ds_pc, 32'h1C000004);
    step(1);
    src_en = 0; fwd_valid = 0;
    // Back-pressure without hazard
    es_allowin = 0; fs2ds_pc = 32'h1C00000C; fs2ds_inst = 32'h3; #1;
    chk("bp_allowin", ds_allowin, 0);
    chk("bp_stall", stall, 0);
    step(1); #1;
    chk("bp_held", ds_pc, 32'h1C000008);
    chk("bp_cnt", stall_cnt, 3);
    es_allowin = 1; #1;
    chk("bp_release", ds_allowin, 1);
    step(1);
    fs2ds_valid = 0; #1;
    chk("bp_accept", ds_pc, 32'h1C00000C);
    // Flush while stalled
    src_en = 2'b01; src_addr[0 +: AW] = 9; set_ch(1, 1, 1, 9, 0, 32'h5); #1;
    chk("fl_stall", stall, 1);
    flush = 1; fs2ds_valid = 1; fs2ds_pc = 32'h1C000010; #1;
    chk("fl_no_issue", ds2es_valid, 0);
    step(1);
    flush = 0; fs2ds_valid = 0; #1;
    chk("fl_dropped", stall, 0);
    chk("fl_pc", ds_pc, 32'h1C00000C);
    chk("fl_cnt", stall_cnt, 3);
    // Reset mid-stall
    fs2ds_valid = 1; fs2ds_pc = 32'h1C000020; step(1);
    fs2ds_valid = 0; step(1);
    chk("rs_stall", stall, 1);
    chk("rs_cnt", stall_cnt, 4);
    reset = 1; step(1);
    chk("rs_pc", ds_pc, 0);
    chk("rs_inst", ds_inst, 0);
    chk("rs_cnt0", stall_cnt, 0);
    chk("rs_allowin", ds_allowin, 1);
    chk("rs_nostall", stall, 0);
    reset = 0;
    // Saturation and clear
    fs2ds_valid = 1; fs2ds_pc = 32'h1C000030; step(1);
    fs2ds_valid = 0; step(20);
    chk("sat_cnt", stall_cnt, 15);
    chk("sat_pc", ds_pc, 32'h1C000030);
    clr_cnt = 1; step(1);
    clr_cnt = 0; #1;
    chk("clr_cnt", stall_cnt, 0);
    step(1);
    chk("clr_resume", stall_cnt, 1);
    flush = 1; step(1);
    flush = 0; step(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/id_bypass_stage.md
Name: id_bypass_stage

Overview:
- Parametrised decode-stage pipeline register, operand bypass network and interlock unit for the five-stage core.
- Holds one {pc, instruction} entry with a valid/allowin handshake to the fetch and execute stages.
- Resolves NSRC register-source operands against NFWD prioritised producer channels. Each channel carries its own data-ready flag, so load-use stalls and multi-cycle-producer stalls are handled by one mechanism.
- Counts stall cycles for performance analysis.

Parameters:
- DATA_W, 32, operand/result width
- PC_W, 32, program counter width
- INST_W, 32, instruction payload width
- AW, 5, register address width
- NSRC, 2, number of source operands resolved
- NFWD, 3, number of bypass channels; index 0 = youngest producer (EX), highest priority
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- fs2ds_valid  in  1  fetch entry valid
- fs2ds_pc  in  PC_W  fetch pc
- fs2ds_inst  in  INST_W  fetch instruction
- ds_allowin  out  1  stage can accept an entry this cycle
- es_allowin  in  1  execute stage can accept
- ds2es_valid  out  1  entry valid and ready to issue
- ds_pc  out  PC_W  registered pc
- ds_inst  out  INST_W  registered instruction (fed to the external decoder)
- flush  in  1  branch/exception flush; kills the held entry
- src_en  in  NSRC  per-source "reads register" flag from the decoder
- src_addr  in  NSRC*AW  per-source register address, source k at [k*AW +: AW]
- rf_rdata  in  NSRC*DATA_W  regfile read data per source
- fwd_valid  in  NFWD  producer stage valid
- fwd_we  in  NFWD  producer writes a register
- fwd_dest  in  NFWD*AW  producer destination
- fwd_ready  in  NFWD  producer result available this cycle (0 for load in EX, busy divider, etc.)
- fwd_data  in  NFWD*DATA_W  producer result
- src_val  out  NSRC*DATA_W  resolved operand values
- stall  out  1  interlock active this cycle
- stall_cnt  out  CNT_W  saturating count of stall cycles
- clr_cnt  in  1  synchronous clear of stall_cnt

Behaviour:
- Reset values: ds_valid=0, ds_pc=0, ds_inst=0, stall_cnt=0. With ds_valid=0, ds2es_valid=0, stall=0 and ds_allowin=1.
- Channel i matches source k when all hold: fwd_valid[i], fwd_we[i], src_en[k], src_addr[k]!=0 and fwd_dest[i]==src_addr[k].
- Operand resolution (combinational, 0-cycle):
  - src_val[k] = fwd_data of the lowest-index matching channel.
  - If no channel matches, src_val[k] = rf_rdata[k].
  - Address 0 never matches, so src_val = rf_rdata (regfile returns 0).
- hazard_k = the lowest-index matching channel has fwd_ready=0. Older ready channels must NOT mask a younger unready match.
- stall = ds_valid & |hazard_k.
- ds_ready_go = ~stall.
- ds2es_valid = ds_valid & ds_ready_go & ~flush.
- ds_allowin = ~ds_valid | (ds_ready_go & es_allowin).
- Sequential update priority: reset > flush > load.
  - flush=1: ds_valid<=0 regardless of fs2ds_valid; ds_pc/ds_inst hold.
  - Otherwise, if ds_allowin: ds_valid<=fs2ds_valid.
  - ds_pc/ds_inst load only when fs2ds_valid & ds_allowin & ~flush; otherwise they hold.
- Stalled entry: held unchanged and re-evaluated each cycle. It issues in the cycle its producer asserts fwd_ready or the match disappears. No minimum stall length.
- stall_cnt update priority: reset or clr_cnt → 0; else stall & ~flush → +1; saturates at all-ones (no wrap).
- Flush while stalled: entry dropped next cycle; the stall cycle is not counted.
- fwd_* inputs for invalid channels are don't-care. Duplicate matches resolve strictly by index.

Test Plan:
- Reset, then entry pc=0x1C000000, inst=0x02800421, src_en=00, es_allowin=1 → ds2es_valid=1 one cycle after fs2ds_valid; ds_pc=0x1C000000; stall=0.
- src_addr0=5; ch0{we,dest=5,ready=1,data=0xAA}; ch1{dest=5,data=0xBB}; rf=0x11 → src_val0=0xAA. Drop ch0 → 0xBB. Drop ch1 → 0x11. src_addr0=0 with ch0 dest=0 → 0x11.
- Load-use: ch0{dest=7,ready=0}, ch2{dest=7,ready=1}, src_addr1=7 → stall=1, ds_allowin=0, ds2es_valid=0 for 3 cycles. Set ch0 ready=1, data=0x1234 → issue with src_val1=0x1234; stall_cnt=3.
- es_allowin=0 with no hazard → entry held, ds_allowin=0, stall=0, stall_cnt unchanged. Raise es_allowin → next fetch entry accepted the same cycle.
- flush during stall, fs2ds_valid=1 → ds_valid=0 next cycle, new entry not captured, ds_pc unchanged. Reset asserted mid-stall → all outputs return to reset values next cycle.
- CNT_W=4: force 20 stall cycles → stall_cnt=15. Pulse clr_cnt → 0.
